// File: rtl/memory_access_unit_pkg.sv
// Shared pipeline definitions for the memory stage: widths, control-signal enums,
// access-size and FSM state types, and the opcode-to-access-size decode.
package memory_access_unit_pkg;

    localparam int WORD       = 32;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic {MEM_WRITE_DIS = 1'b0, MEM_WRITE_EN = 1'b1} mem_write_signal;
    typedef enum logic {REG_FILE_WRITE_DIS = 1'b0, REG_FILE_WRITE_EN = 1'b1} reg_file_write_sig;
    typedef enum logic {ALU_SOURCE = 1'b0, MEM_SOURCE = 1'b1} reg_file_data_source;

    typedef enum logic [1:0] {SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2} mem_access_size;
    typedef enum logic {MEM_IDLE = 1'b0, MEM_BUSY = 1'b1} mem_fsm_state;

    // op = {opA[3:0], opB[2:0]}; anything not listed falls back to a word access.
    function automatic mem_access_size decode_size(input logic [6:0] op);
        mem_access_size size;
        size = SIZE_WORD;
        case (op[6:3])
            4'b0101: begin
                case (op[2:0])
                    3'b001, 3'b101, 3'b111: size = SIZE_HALF;
                    3'b010, 3'b011, 3'b110: size = SIZE_BYTE;
                    default:                size = SIZE_WORD;
                endcase
            end
            4'b0111: size = SIZE_BYTE;
            4'b1000: size = SIZE_HALF;
            default: size = SIZE_WORD;
        endcase
        return size;
    endfunction

    function automatic logic decode_signed(input logic [6:0] op);
        return (op[6:3] == 4'b0101) && ((op[2:0] == 3'b011) || (op[2:0] == 3'b111));
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the data bus: store byte enables and lane replication,
// load lane selection with sign/zero extension, and misalignment detection.
module load_store_align
    import memory_access_unit_pkg::*;
(
    input  mem_access_size     size_i,
    input  logic               signed_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [WORD-1:0]    st_data_i,
    input  logic [WORD-1:0]    rd_data_i,
    output logic [3:0]         be_o,
    output logic [WORD-1:0]    wdata_o,
    output logic [WORD-1:0]    ld_data_o,
    output logic               misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel     = rd_data_i[{addr_lo_i, 3'b000} +: 8];
        half_sel     = addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];
        be_o         = 4'b1111;
        wdata_o      = st_data_i;
        ld_data_o    = rd_data_i;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = signed_i ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            end
            SIZE_HALF: begin
                // A set addr[0] is simply dropped; the access still uses the half picked by addr[1].
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{st_data_i[15:0]}};
                ld_data_o    = signed_i ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                misaligned_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Pipeline memory stage: issues one bus access per load/store with a req/ack handshake,
// stalls upstream while it is outstanding, and drives the MEM/WB register.
module memory_access_unit
    import memory_access_unit_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   is_valid_i,
    input  mem_write_signal        mem_write_en_i,
    input  reg_file_write_sig      reg_file_write_en_i,
    input  reg_file_data_source    reg_file_data_source_i,
    input  logic [6:0]             opA_opB_i,
    input  logic [ADDR_WIDTH-1:0]  reg_dest_addr_i,
    input  logic [WORD-1:0]        alu_result_i,
    input  logic [WORD-1:0]        reg_2_data_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [WORD-1:0]        mem_addr_o,
    output logic [3:0]             mem_be_o,
    output logic [WORD-1:0]        mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic [WORD-1:0]        mem_rdata_i,
    output logic                   stall_o,
    output logic                   align_fault_o,
    output logic                   is_valid_o,
    output reg_file_write_sig      reg_file_write_en_o,
    output logic [ADDR_WIDTH-1:0]  reg_dest_addr_o,
    output logic [WORD-1:0]        wb_data_o
);

    mem_fsm_state           state_q, state_d;
    mem_access_size         size_q, size_d, size_sel;
    logic                   signed_q, signed_d, signed_sel;
    logic [1:0]             lane_q, lane_d, lane_sel;
    logic                   is_load_q, is_load_d;
    reg_file_write_sig      reg_we_q, reg_we_d;
    logic [ADDR_WIDTH-1:0]  dest_q, dest_d;
    logic [WORD-1:0]        alu_q, alu_d;
    logic                   req_q, req_d, we_q, we_d;
    logic [WORD-1:0]        addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic                   wb_valid_q, wb_valid_d;
    reg_file_write_sig      wb_we_q, wb_we_d;
    logic [ADDR_WIDTH-1:0]  wb_dest_q, wb_dest_d;
    logic [WORD-1:0]        wb_data_q, wb_data_d;

    logic                   mem_op;
    logic [3:0]             be_calc;
    logic [WORD-1:0]        wdata_calc, ld_calc;
    logic                   misaligned;

    assign mem_op = is_valid_i && ((mem_write_en_i == MEM_WRITE_EN) ||
                                   (reg_file_data_source_i == MEM_SOURCE));

    // One aligner serves both phases: issue fields in IDLE, the latched load lane in BUSY.
    assign size_sel   = (state_q == MEM_BUSY) ? size_q   : decode_size(opA_opB_i);
    assign signed_sel = (state_q == MEM_BUSY) ? signed_q : decode_signed(opA_opB_i);
    assign lane_sel   = (state_q == MEM_BUSY) ? lane_q   : alu_result_i[1:0];

    load_store_align u_align (
        .size_i       (size_sel),
        .signed_i     (signed_sel),
        .addr_lo_i    (lane_sel),
        .st_data_i    (reg_2_data_i),
        .rd_data_i    (mem_rdata_i),
        .be_o         (be_calc),
        .wdata_o      (wdata_calc),
        .ld_data_o    (ld_calc),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        signed_d      = signed_q;
        lane_d        = lane_q;
        is_load_d     = is_load_q;
        reg_we_d      = reg_we_q;
        dest_d        = dest_q;
        alu_d         = alu_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        wb_valid_d    = 1'b0;
        wb_we_d       = wb_we_q;
        wb_dest_d     = wb_dest_q;
        wb_data_d     = wb_data_q;
        stall_o       = 1'b0;
        align_fault_o = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_op) begin
                    stall_o       = 1'b1;
                    align_fault_o = misaligned && !reset_i;
                    state_d       = MEM_BUSY;
                    size_d        = size_sel;
                    signed_d      = signed_sel;
                    lane_d        = lane_sel;
                    is_load_d     = (reg_file_data_source_i == MEM_SOURCE);
                    reg_we_d      = reg_file_write_en_i;
                    dest_d        = reg_dest_addr_i;
                    alu_d         = alu_result_i;
                    req_d         = 1'b1;
                    we_d          = (mem_write_en_i == MEM_WRITE_EN);
                    addr_d        = {alu_result_i[WORD-1:2], 2'b00};
                    be_d          = be_calc;
                    wdata_d       = wdata_calc;
                end else begin
                    wb_valid_d = is_valid_i;
                    wb_we_d    = is_valid_i ? reg_file_write_en_i : REG_FILE_WRITE_DIS;
                    wb_dest_d  = reg_dest_addr_i;
                    wb_data_d  = alu_result_i;
                end
            end
            MEM_BUSY: begin
                if (mem_ack_i) begin
                    state_d    = MEM_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = reg_we_q;
                    wb_dest_d  = dest_q;
                    wb_data_d  = is_load_q ? ld_calc : alu_q;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= MEM_IDLE;
            size_q     <= SIZE_WORD;
            signed_q   <= 1'b0;
            lane_q     <= 2'b00;
            is_load_q  <= 1'b0;
            reg_we_q   <= REG_FILE_WRITE_DIS;
            dest_q     <= '0;
            alu_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= REG_FILE_WRITE_DIS;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            lane_q     <= lane_d;
            is_load_q  <= is_load_d;
            reg_we_q   <= reg_we_d;
            dest_q     <= dest_d;
            alu_q      <= alu_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign mem_req_o           = req_q;
    assign mem_we_o            = we_q;
    assign mem_addr_o          = addr_q;
    assign mem_be_o            = be_q;
    assign mem_wdata_o         = wdata_q;
    assign is_valid_o          = wb_valid_q;
    assign reg_file_write_en_o = wb_we_q;
    assign reg_dest_addr_o     = wb_dest_q;
    assign wb_data_o           = wb_data_q;

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory stage of the pipelined core: consumes the EX/MEM pipeline register outputs, performs loads/stores on the data-memory bus, and produces the MEM/WB register contents. It runs a req/ack handshake with byte-lane steering and load sign/zero extension, and stalls the upstream pipeline while an access is outstanding.

## Interface
- WORD, 32: data/address width (shared package constant).
- ADDR_WIDTH, 4: register-file address width (shared package constant).
- clk_i  in  1  clock; single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- is_valid_i  in  1  EX/MEM entry is valid.
- mem_write_en_i  in  mem_write_signal  store request (MEM_WRITE_EN).
- reg_file_write_en_i  in  reg_file_write_sig  writeback enable.
- reg_file_data_source_i  in  reg_file_data_source  MEM_SOURCE marks a load.
- opA_opB_i  in  7  {opA[3:0], opB[2:0]}; selects access size and signedness.
- reg_dest_addr_i  in  ADDR_WIDTH  writeback register.
- alu_result_i  in  WORD  effective address, or the ALU result for non-memory instructions.
- reg_2_data_i  in  WORD  store data.
- mem_req_o  out  1  bus request, registered.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  WORD  word-aligned address ({addr[WORD-1:2], 2'b00}).
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  WORD  lane-replicated store data.
- mem_ack_i  in  1  one-cycle completion strobe.
- mem_rdata_i  in  WORD  read data, valid with mem_ack_i.
- stall_o  out  1  combinational; EX/MEM and earlier stages must hold while high.
- align_fault_o  out  1  one-cycle pulse on a misaligned access.
- is_valid_o, reg_file_write_en_o, reg_dest_addr_o, wb_data_o  out  1/sig/ADDR_WIDTH/WORD  MEM/WB register.

## Operation
- Memory op: is_valid_i && (mem_write_en_i == MEM_WRITE_EN || reg_file_data_source_i == MEM_SOURCE).
- Size decode:
  - opA 0101, opB: 000 STR, 001 STRH, 010 STRB, 011 LDRSB, 100 LDR, 101 LDRH, 110 LDRB, 111 LDRSH.
  - opA 0110 and 1001: word. opA 0111: byte. opA 1000: halfword. All unsigned.
  - Any other opA with a memory op: word.
- Byte enables:
  - Byte: one-hot on addr[1:0].
  - Half: 0011 if addr[1]=0, else 1100.
  - Word: 1111.
- Store data: byte replicated ×4; half replicated ×2.
- Load data: lane selected by addr[1:0], then zero- or sign-extended to WORD.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - The access proceeds with the ignored low bits dropped.
  - align_fault_o pulses in the issue cycle.
- FSM states:
  - IDLE: memory op present → latch address, data, be, size and control; go to BUSY.
  - BUSY: mem_req_o=1 with all bus outputs stable; mem_ack_i → capture data, go to IDLE.
- Non-memory valid entries and invalid entries pass to MEM/WB with wb_data_o = alu_result_i and no bus activity.
- stall_o = (IDLE && memory op) || (BUSY && !mem_ack_i).
- mem_ack_i is ignored in IDLE.

## Timing
- Reset values: FSM IDLE; mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, align_fault_o=0, is_valid_o=0, reg_file_write_en_o=disabled, reg_dest_addr_o=0, wb_data_o=0.
- Non-memory instruction: MEM/WB outputs update at the next clock edge (1-cycle latency, no stall).
- Memory op presented in cycle 0:
  - stall_o is high in cycle 0.
  - mem_req_o rises in cycle 1.
  - If ack arrives in cycle k ≥ 1, stall_o is low in cycle k; MEM/WB shows the result and mem_req_o=0 in cycle k+1.
  - Minimum occupancy is 2 cycles.
- While stall_o is high, MEM/WB holds is_valid_o=0 (bubble). The upstream input is held stable.
- Back-to-back memory ops: the next op is seen in IDLE in cycle k+1 and issues immediately, so there is no dead cycle beyond the IDLE issue cycle.
- Reset mid-access: the next cycle is IDLE with mem_req_o=0. A late ack is dropped and no writeback occurs.
- Stores write back only if reg_file_write_en_i is set; wb_data_o is then alu_result_i.

## Structure
- Shared package (GENERAL_DEFS):
  - existing: WORD, ADDR_WIDTH, mem_write_signal, reg_file_write_sig, reg_file_data_source.
  - new: mem_access_size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the mem_fsm_state enum.
- Sub-module load_store_align (combinational): takes size, signed flag, addr[1:0], store data and read data; produces be, wdata and the extended load value.

## Test plan
- ADD result 0x0000_1234, not a memory op → wb_data_o=0x0000_1234 next cycle; stall_o never high; mem_req_o stays 0.
- STRB (0101/010), addr 0x0000_2003, data 0x0000_00AB → mem_be_o=1000, mem_wdata_o=0xABAB_ABAB, mem_addr_o=0x0000_2000; ack after 3 cycles releases stall.
- LDRSH (0101/111), addr 0x0000_3002, rdata 0x8001_7FFF → wb_data_o=0xFFFF_8001; LDRH at the same address → 0x0000_8001.
- LDR addr 0x0000_4001 → align_fault_o pulses once; mem_addr_o=0x0000_4000, mem_be_o=1111.
- reset_i asserted in BUSY with ack arriving the next cycle → mem_req_o=0, is_valid_o=0, no writeback.
- Two back-to-back LDRs, each acked on the first request cycle → every op sees exactly 1 stall cycle; results appear in order.
